uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//   Byte queue and send sequencer between the keyboard path (ScanCodeToAscii output)
//   and async_transmitter. It buffers ASCII bytes in a FIFO so that keystrokes arriving
//   while the transmitter is busy are not lost. It issues exactly one txStart per byte
//   and respects TxD_busy. It replaces the direct scan_code_ready -> TxD_start wiring.
// PARAMETERS
//   DEPTH         16   FIFO entries; power of 2, >= 2
//   BUSY_TIMEOUT  8    cycles to wait for txBusy to rise after txStart; >= 2
// PORTS
//   clk          in   1              system clock (100 MHz domain)
//   rst          in   1              asynchronous, active-high reset
//   dataValid    in   1              one-cycle strobe: data holds a byte to queue
//   data         in   8              ASCII byte to queue
//   txBusy       in   1              TxD_busy from async_transmitter
//   txStart      out  1              one-cycle start pulse to async_transmitter
//   txData       out  8              byte for async_transmitter; stable while txStart is high
//   count        out  $clog2(DEPTH)+1  bytes currently queued (0..DEPTH)
//   full         out  1              count == DEPTH
//   overflow     out  1              sticky: a byte was dropped because the FIFO was full
// BEHAVIOUR
//   Reset: clk and rst only; rst is asynchronous and active-high. All state clears
//     immediately on rst. Outputs: txStart=0, txData=0, count=0, full=0, overflow=0,
//     FSM=IDLE, read/write pointers=0. A send in flight is abandoned and the FIFO
//     contents are discarded.
//   FIFO: circular buffer with wrapping pointers of $clog2(DEPTH) bits. count, full and
//     overflow are registered.
//   Push: on an edge where dataValid=1 and full=0 (registered value), write data at wptr
//     and increment wptr. If full=1 the byte is dropped and overflow <= 1. No same-cycle
//     bypass: a push while full is rejected even if a pop happens in the same cycle.
//   Pop: happens only on the IDLE->START transition (see FSM).
//   count update: push only +1; pop only -1; push and pop together: unchanged.
//     count never wraps.
//   FSM states:
//     IDLE       if count != 0 && txBusy == 0: txData <= mem[rptr], rptr++, pop,
//                -> START
//     START      txStart=1 for exactly this cycle; -> WAIT_BUSY
//     WAIT_BUSY  txBusy==1 -> WAIT_DONE; after BUSY_TIMEOUT cycles without txBusy,
//                -> IDLE (the byte counts as sent and is not retried)
//     WAIT_DONE  txBusy==0 -> IDLE
//   txStart is a registered output, high only in START. txData holds its value until
//     the next pop.
//   Latency: with an empty FIFO, an idle transmitter and dataValid high in cycle 0,
//     txStart is high in cycle 2.
//   Throughput: at most one byte per transmitter frame. Back-to-back frames are
//     separated by at least 2 clk (WAIT_DONE -> IDLE -> START).
//   Never issues txStart while txBusy=1 is sampled in IDLE.
//   Ordering: bytes are transmitted in strict FIFO order.
// TESTING
//   1 Single byte: push 0x41, txBusy model rises 1 cycle after start, lasts 20 cycles
//     -> txStart in cycle 2, txData=0x41, exactly 1 pulse, count returns to 0.
//   2 Burst: push 0x61..0x70 (16 bytes) on consecutive cycles with a slow txBusy
//     -> full=1 after the 16th push, overflow=0, 16 pulses in order 0x61..0x70.
//   3 Overflow: fill to DEPTH while txBusy is held at 1, then push 0x7A -> 0x7A is
//     dropped, overflow=1 and stays 1, count=16.
//   4 Simultaneous push/pop: count=3, push on the IDLE->START edge -> count stays 3,
//     order preserved.
//   5 Timeout: txBusy tied to 0, push 0x31, 0x32 -> two txStart pulses spaced
//     BUSY_TIMEOUT+2 cycles apart.
//   6 Reset mid-send: assert rst during WAIT_DONE with count=5 -> all outputs 0
//     immediately; after release there is no txStart until a new push.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Byte queue and send sequencer that sits between the keyboard path
//   (ScanCodeToAscii output) and async_transmitter. Incoming ASCII bytes are
//   buffered in a circular FIFO, so keystrokes that arrive while the
//   transmitter is busy are not lost. Each byte produces exactly one txStart
//   pulse, and the sequencer never starts a frame while the transmitter
//   reports busy.
//
// Ports
//   clk        system clock (100 MHz domain)
//   rst        asynchronous, active-high reset; clears all state at once
//   dataValid  one-cycle strobe: data holds a byte to queue
//   data       ASCII byte to queue
//   txBusy     TxD_busy from async_transmitter
//   txStart    registered one-cycle start pulse to async_transmitter
//   txData     byte for async_transmitter; held until the next pop
//   count      number of bytes currently queued (0..DEPTH)
//   full       count == DEPTH (registered)
//   overflow   sticky flag: a byte was dropped because the FIFO was full
//
// Parameters
//   DEPTH         FIFO entries; power of 2, >= 2
//   BUSY_TIMEOUT  cycles to wait for txBusy to rise after txStart; >= 2

module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dataValid,
  input  logic [7:0]             data,
  input  logic                   txBusy,
  output logic                   txStart,
  output logic [7:0]             txData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT);

  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_END = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [TW-1:0] timer;
  logic          push;
  logic          pop;
  logic [AW:0]   count_next;

  // A push is decided on the registered full flag only, so a byte offered
  // while full is dropped even if a pop frees a slot on the same edge.
  assign push = dataValid && !full;

  // The only place a byte leaves the FIFO is the IDLE->START transition,
  // and that transition is blocked while the transmitter reports busy.
  assign pop = (state == IDLE) && (count != '0) && !txBusy;

  // Next occupancy; push and pop together leave it unchanged. push is
  // impossible at DEPTH and pop impossible at 0, so this cannot wrap.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array. It is deliberately not reset: after reset both pointers
  // and count are zero, so stale entries can never be read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data;
    end
  end

  // Write side and occupancy flags. full is registered from the next
  // count so that it lines up exactly with count; overflow is sticky
  // until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      if (dataValid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Send sequencer. txData is loaded on the pop so it is already stable
  // while txStart is high. WAIT_BUSY gives the transmitter BUSY_TIMEOUT
  // cycles to acknowledge; if it never does, the byte is treated as sent
  // so a missing or stuck transmitter cannot stall the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rptr    <= '0;
      txStart <= 1'b0;
      txData  <= 8'h00;
      timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          txStart <= 1'b0;
          if (pop) begin
            txData  <= mem[rptr];
            rptr    <= rptr + 1'b1;
            txStart <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          txStart <= 1'b0;
          timer   <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          txStart <= 1'b0;
          if (txBusy) begin
            state <= WAIT_DONE;
          end else if (timer == TIMER_END) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          txStart <= 1'b0;
          if (!txBusy) begin
            state <= IDLE;
          end
        end
        default: begin
          txStart <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
//   Self-checking bench for uart_tx_queue. A negedge monitor keeps a
//   scoreboard queue of accepted bytes: bytes are pushed when the bench
//   offers them and the queue has room, and popped and compared against
//   txData on every txStart pulse. count/full/overflow are tracked against
//   the scoreboard every cycle. A small transmitter model drives txBusy.

module tb_uart_tx_queue;

  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 8;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_HIGH   = 1;
  localparam int MODE_LOW    = 2;

  logic       clk;
  logic       rst;
  logic       dataValid;
  logic [7:0] data;
  logic       txBusy;
  logic       txStart;
  logic [7:0] txData;
  logic [4:0] count;
  logic       full;
  logic       overflow;

  int total;
  int bad;
  int cyc;
  int pulses;
  int p_last;
  int p_prev;
  int mode;
  int busy_len;
  int rem;
  bit chk_en;
  bit m_ovf;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] din;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[17];

  uart_tx_queue #(
    .DEPTH(DEPTH),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dataValid(dataValid),
    .data(data),
    .txBusy(txBusy),
    .txStart(txStart),
    .txData(txData),
    .count(count),
    .full(full),
    .overflow(overflow)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure pulse spacing
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    dataValid = 1'b1;
    data      = b;
    tick();
    dataValid = 1'b0;
  endtask

  task automatic waitPulses(input string name, input int target, input int limit);
    int n;
    n = 0;
    while (pulses < target && n < limit) begin
      tick();
      n++;
    end
    checkOutput(name, (pulses >= target), 1);
  endtask

  task automatic doReset();
    chk_en = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    sb_q.delete();
    m_ovf = 1'b0;
    rst   = 1'b0;
    chk_en = 1'b1;
    tick();
  endtask

  // Transmitter model: in normal mode txBusy rises one cycle after the start
  // pulse and stays high for busy_len cycles. It updates at negedge so a mode
  // change made at a posedge takes effect before the next DUT sampling edge.
  always @(negedge clk) begin
    if (mode == MODE_HIGH) begin
      txBusy = 1'b1;
      rem    = 0;
    end else if (mode == MODE_LOW) begin
      txBusy = 1'b0;
      rem    = 0;
    end else if (txStart) begin
      rem = busy_len;
    end else if (rem > 0) begin
      txBusy = 1'b1;
      rem--;
    end else begin
      txBusy = 1'b0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst && chk_en) begin
      if (txStart) begin
        pulses++;
        p_prev = p_last;
        p_last = cyc;
        checkOutput("pop_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_b = sb_q.pop_front();
          checkOutput("tx_order", txData, exp_b);
        end
      end
      checkOutput("count_track", count, sb_q.size());
      checkOutput("full_track", full, (sb_q.size() == DEPTH));
      checkOutput("ovf_track", overflow, m_ovf);
      if (dataValid) begin
        if (sb_q.size() < DEPTH) sb_q.push_back(data);
        else m_ovf = 1'b1;
      end
    end
  end

  initial begin
    int c0;
    int p0;

    for (int i = 0; i < 16; i++) begin
      tbl[i].din       = 8'h41 + 8'(i);
      tbl[i].exp_count = 5'(i + 1);
      tbl[i].exp_full  = (i == 15);
      tbl[i].exp_ovf   = 1'b0;
    end
    tbl[16].din       = 8'h7A;
    tbl[16].exp_count = 5'd16;
    tbl[16].exp_full  = 1'b1;
    tbl[16].exp_ovf   = 1'b1;

    total = 0; bad = 0; pulses = 0; p_last = 0; p_prev = 0;
    mode = MODE_LOW; busy_len = 20; rem = 0; txBusy = 1'b0;
    m_ovf = 1'b0; chk_en = 1'b0;
    dataValid = 1'b0; data = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_txStart", txStart, 0);
    checkOutput("rst_txData", txData, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_overflow", overflow, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single byte, latency and pulse count
    mode = MODE_NORMAL; busy_len = 20;
    tick();
    p0 = pulses;
    c0 = cyc;
    applyStimulus(8'h41);
    waitPulses("single_wait", p0 + 1, 20);
    checkOutput("single_latency", p_last - c0, 2);
    repeat (30) tick();
    checkOutput("single_pulses", pulses - p0, 1);
    checkOutput("single_txData", txData, 8'h41);
    checkOutput("single_count", count, 0);

    // Burst of 16 with transmitter held busy, then drain in order
    mode = MODE_HIGH;
    tick();
    tick();
    for (int i = 0; i < 16; i++) applyStimulus(8'h61 + 8'(i));
    checkOutput("burst_full", full, 1);
    checkOutput("burst_count", count, 16);
    checkOutput("burst_ovf", overflow, 0);
    p0 = pulses;
    mode = MODE_NORMAL; busy_len = 4;
    waitPulses("burst_drain", p0 + 16, 400);
    repeat (10) tick();
    checkOutput("burst_empty", count, 0);
    checkOutput("burst_last", txData, 8'h70);

    // Overflow, table driven
    mode = MODE_HIGH;
    tick();
    tick();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].din);
      checkOutput("tbl_count", count, tbl[i].exp_count);
      checkOutput("tbl_full", full, tbl[i].exp_full);
      checkOutput("tbl_ovf", overflow, tbl[i].exp_ovf);
    end
    repeat (5) tick();
    checkOutput("ovf_sticky", overflow, 1);
    p0 = pulses;
    mode = MODE_NORMAL;
    waitPulses("ovf_drain", p0 + 16, 400);
    repeat (10) tick();
    checkOutput("ovf_after_drain", overflow, 1);
    checkOutput("ovf_drain_count", count, 0);
    checkOutput("ovf_last", txData, 8'h50);
    doReset();
    checkOutput("ovf_cleared", overflow, 0);

    // Simultaneous push and pop
    mode = MODE_HIGH;
    tick();
    tick();
    applyStimulus(8'h51);
    applyStimulus(8'h52);
    applyStimulus(8'h53);
    checkOutput("pp_count3", count, 3);
    p0 = pulses;
    mode = MODE_NORMAL;
    dataValid = 1'b1;
    data = 8'h54;
    tick();
    dataValid = 1'b0;
    checkOutput("pp_start", txStart, 1);
    checkOutput("pp_count_hold", count, 3);
    checkOutput("pp_first", txData, 8'h51);
    waitPulses("pp_drain", p0 + 4, 200);
    repeat (10) tick();
    checkOutput("pp_empty", count, 0);

    // Timeout with transmitter that never goes busy
    mode = MODE_LOW;
    tick();
    p0 = pulses;
    applyStimulus(8'h31);
    applyStimulus(8'h32);
    waitPulses("to_wait", p0 + 2, 60);
    checkOutput("to_gap", p_last - p_prev, BUSY_TIMEOUT + 2);
    repeat (15) tick();
    checkOutput("to_pulses", pulses - p0, 2);
    checkOutput("to_txData", txData, 8'h32);

    // Reset mid-send with bytes queued
    mode = MODE_NORMAL; busy_len = 30;
    tick();
    for (int i = 0; i < 6; i++) applyStimulus(8'h21 + 8'(i));
    repeat (3) tick();
    checkOutput("mid_count5", count, 5);
    checkOutput("mid_busy", txBusy, 1);
    chk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_txStart", txStart, 0);
    checkOutput("mid_rst_txData", txData, 0);
    checkOutput("mid_rst_count", count, 0);
    checkOutput("mid_rst_full", full, 0);
    checkOutput("mid_rst_ovf", overflow, 0);
    mode = MODE_LOW;
    tick();
    sb_q.delete();
    m_ovf = 1'b0;
    rst = 1'b0;
    chk_en = 1'b1;
    p0 = pulses;
    repeat (20) tick();
    checkOutput("mid_no_start", pulses - p0, 0);
    mode = MODE_NORMAL; busy_len = 5;
    applyStimulus(8'h7E);
    waitPulses("mid_new", p0 + 1, 20);
    checkOutput("mid_new_data", txData, 8'h7E);
    repeat (15) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
